// File: rtl/mem_cmd_ctrl.sv
// Command front-end for a single-port RAM: in-order command FIFO, one-cycle
// RAM accesses, registered read responses, and an init sweep after reset.
module mem_cmd_ctrl #(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              init_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0]     FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   SWEEP_END  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_EXEC,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  // FIFO storage and bookkeeping
  logic              fifo_we_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop, fifo_nempty;

  // Registered outputs and internal state
  logic              cmd_ready_q, cmd_ready_d;
  logic              init_done_q, init_done_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [ADDR_W:0]   sweep_q, sweep_d;

  assign push        = cmd_valid & cmd_ready_q;
  assign fifo_nempty = (count_q != '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:    if (sweep_q == SWEEP_END) state_d = S_IDLE;
      S_IDLE:    if (fifo_nempty) state_d = S_EXEC;
      S_EXEC: begin
        if (!mem_we_q)        state_d = S_CAPTURE;
        else if (fifo_nempty) state_d = S_EXEC;
        else                  state_d = S_IDLE;
      end
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    if (rsp_ready) state_d = S_IDLE;
      default:   state_d = S_INIT;
    endcase
  end

  // Output / datapath next values, including FIFO pop
  always_comb begin
    pop         = 1'b0;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_addr_d  = rsp_addr_q;
    rd_addr_d   = rd_addr_q;
    mem_addr_d  = mem_addr_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_din_d   = mem_din_q;
    case (state_q)
      S_INIT: begin
        if (sweep_q != SWEEP_END) begin
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = sweep_q[ADDR_W-1:0];
          mem_din_d  = INIT_VALUE;
          sweep_d    = sweep_q + 1'b1;
        end else begin
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        mem_en_d = 1'b0;
        if (fifo_nempty) begin
          pop        = 1'b1;
          mem_en_d   = 1'b1;
          mem_we_d   = fifo_we_q[rd_ptr_q];
          mem_addr_d = fifo_addr_q[rd_ptr_q];
          mem_din_d  = fifo_data_q[rd_ptr_q];
        end
      end
      S_EXEC: begin
        if (mem_we_q) begin
          // Writes chain directly into the next queued command.
          if (fifo_nempty) begin
            pop        = 1'b1;
            mem_en_d   = 1'b1;
            mem_we_d   = fifo_we_q[rd_ptr_q];
            mem_addr_d = fifo_addr_q[rd_ptr_q];
            mem_din_d  = fifo_data_q[rd_ptr_q];
          end else begin
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
          end
        end else begin
          mem_en_d  = 1'b0;
          rd_addr_d = mem_addr_q;
        end
      end
      S_CAPTURE: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = mem_dout;
        rsp_addr_d  = rd_addr_q;
      end
      S_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // FIFO occupancy and ready derived from next registered state
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    cmd_ready_d = init_done_d & (count_d != FULL_COUNT);
  end

  // Registered datapath, pointers and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_addr_q  <= '0;
      rd_addr_q   <= '0;
      mem_addr_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_din_q   <= '0;
      sweep_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_addr_q  <= rsp_addr_d;
      rd_addr_q   <= rd_addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_din_q   <= mem_din_d;
      sweep_q     <= sweep_d;
    end
  end

  // FIFO storage write on accepted command
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we_q[wr_ptr_q]   <= cmd_we;
      fifo_addr_q[wr_ptr_q] <= cmd_addr;
      fifo_data_q[wr_ptr_q] <= cmd_wdata;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_addr  = rsp_addr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_cmd_ctrl.sv
// Bench for mem_cmd_ctrl: RAM behavioural model on the mem_* pins, a
// memory-image/expected-response scoreboard, directed and random traffic.
module tb_mem_cmd_ctrl;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int NW = 1 << AW;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] rsp_addr;
  logic          init_done;
  logic [AW-1:0] mem_addr;
  logic          mem_en, mem_we;
  logic [DW-1:0] mem_din, mem_dout;

  mem_cmd_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .INIT_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
    .init_done(init_done),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // RAM: registered read, no reset; starts with non-zero garbage
  logic [DW-1:0] ram [NW];
  initial begin
    for (int i = 0; i < NW; i++) ram[i] = 8'hEE;
    mem_dout = 8'hEE;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        mem_dout <= ram[mem_addr];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rsp_t;

  int unsigned   checks = 0;
  int unsigned   failures = 0;
  logic [DW-1:0] exp_mem [NW];
  rsp_t          exp_q [$];
  bit            cmd_fired;
  int            en_run, en_max;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model from handshakes seen this cycle, then advance
  task automatic step();
    bit            pv;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    rsp_t          e;
    cmd_fired = cmd_valid && cmd_ready;
    if (cmd_fired) begin
      if (cmd_we) exp_mem[cmd_addr] = cmd_wdata;
      else begin
        e.addr = cmd_addr;
        e.data = exp_mem[cmd_addr];
        exp_q.push_back(e);
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_spurious", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_addr", rsp_addr, e.addr);
        chk("rsp_rdata", rsp_rdata, e.data);
      end
    end
    pv = rsp_valid && !rsp_ready;
    pa = rsp_addr;
    pd = rsp_rdata;
    @(posedge clk);
    #1;
    if (pv && !rst) begin
      chk("rsp_hold_valid", rsp_valid, 1);
      chk("rsp_hold_addr", rsp_addr, pa);
      chk("rsp_hold_data", rsp_rdata, pd);
    end
    if (mem_en) en_run++;
    else        en_run = 0;
    if (en_run > en_max) en_max = en_run;
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int i = 0; i < 60 && !ok; i++) begin
      step();
      ok = cmd_fired;
    end
    if (!ok) chk("cmd_accept_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    chk("drain_done", exp_q.size(), 0);
    repeat (3) step();
  endtask

  // Called right after reset deasserts between edges
  task automatic check_init_sweep();
    for (int i = 0; i < NW; i++) begin
      step();
      chk("init_en", mem_en, 1);
      chk("init_we", mem_we, 1);
      chk("init_addr", mem_addr, i);
      chk("init_din", mem_din, 8'h00);
      chk("init_ready_low", cmd_ready, 0);
      chk("init_done_low", init_done, 0);
    end
    step();
    chk("post_init_en", mem_en, 0);
    chk("post_init_done", init_done, 1);
    chk("post_init_ready", cmd_ready, 1);
    for (int i = 0; i < NW; i++) exp_mem[i] = 8'h00;
  endtask

  initial begin
    bit ok;
    logic [AW-1:0] qa;
    logic [DW-1:0] qd;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    en_run = 0;
    en_max = 0;
    for (int i = 0; i < NW; i++) exp_mem[i] = 8'hEE;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    check_init_sweep();

    // Read of addr 5 after sweep returns 00
    send_cmd(1'b0, 3'd5, 8'h00);
    drain();

    // Write A5 @3: single write cycle, then read latency of 3 cycles
    send_cmd(1'b1, 3'd3, 8'hA5);
    step();
    chk("wr_en", mem_en, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 3);
    chk("wr_din", mem_din, 8'hA5);
    step();
    chk("wr_en_drop", mem_en, 0);
    step();
    send_cmd(1'b0, 3'd3, 8'h00);
    step();
    chk("rd_exec_en", mem_en, 1);
    chk("rd_exec_we", mem_we, 0);
    chk("rd_lat1_valid", rsp_valid, 0);
    step();
    chk("rd_lat2_valid", rsp_valid, 0);
    step();
    chk("rd_lat3_valid", rsp_valid, 1);
    chk("rd_lat3_data", rsp_rdata, 8'hA5);
    chk("rd_lat3_addr", rsp_addr, 3);
    drain();

    // Eight back-to-back writes, then read all back
    en_run = 0;
    en_max = 0;
    for (int i = 0; i < NW; i++) send_cmd(1'b1, AW'(i), DW'(8'h10 + i));
    repeat (4) step();
    chk("b2b_en_run", en_max, 8);
    for (int i = 0; i < NW; i++) send_cmd(1'b0, AW'(i), 8'h00);
    drain();

    // Backpressure: read stuck in response, FIFO fills with 4, 5th refused
    rsp_ready = 1'b0;
    send_cmd(1'b0, 3'd0, 8'h00);
    for (int k = 0; k < 4; k++)
      send_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, NW - 1)), DW'($urandom));
    chk("full_ready_low", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = AW'($urandom_range(0, NW - 1));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("full_no_push", cmd_fired, 0);
    end
    chk("bp_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      step();
      ok = cmd_fired;
    end
    chk("bp_fifth_accepted", ok, 1);
    drain();

    // Push and pop in the same cycle with 3 queued
    rsp_ready = 1'b0;
    send_cmd(1'b0, 3'd6, 8'h00);
    qa = AW'($urandom_range(0, NW - 1));
    qd = DW'($urandom);
    send_cmd(1'b1, qa, qd);
    send_cmd(1'b1, AW'(qa + 3'd1), DW'($urandom));
    send_cmd(1'b1, AW'(qa + 3'd2), DW'($urandom));
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (rsp_valid) ok = 1;
      else step();
    end
    chk("pp_rsp_valid", rsp_valid, 1);
    chk("pp_ready_at3", cmd_ready, 1);
    rsp_ready = 1'b1;
    step();
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = qa;
    step();
    chk("pp_push_fired", cmd_fired, 1);
    chk("pp_pop_en", mem_en, 1);
    chk("pp_ready_still", cmd_ready, 1);
    cmd_valid = 1'b0;
    drain();

    // Reset while a response is pending
    send_cmd(1'b1, 3'd2, 8'h77);
    drain();
    rsp_ready = 1'b0;
    send_cmd(1'b0, 3'd2, 8'h00);
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (rsp_valid) ok = 1;
      else step();
    end
    chk("mid_rsp_valid", rsp_valid, 1);
    chk("mid_rsp_data", rsp_rdata, 8'h77);
    rst = 1'b1;
    #1;
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_init_done", init_done, 0);
    chk("async_cmd_ready", cmd_ready, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    check_init_sweep();
    send_cmd(1'b0, 3'd2, 8'h00);
    drain();

    // Random traffic against the scoreboard
    for (int k = 0; k < 400; k++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_we    = 1'($urandom_range(0, 1));
      cmd_addr  = AW'($urandom_range(0, NW - 1));
      cmd_wdata = DW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
